// File: rtl/div_iter.sv
// Multi-cycle restoring divider beside ex: one shift-subtract step per clock,
// returns {remainder, quotient} with a start/ready handshake and annul.
//
// state  | meaning
// FREE   | idle, waiting for start_i (annul_i blocks a new request)
// BYZERO | divisor was zero, two-edge wait before reporting a zero result
// ON     | iterating, one quotient bit per edge
// END    | result valid, held until start_i drops
module div_iter #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     dvd_q, dvd_d;
    logic [DATA_W-1:0]     dvs_q, dvs_d;
    logic [DATA_W-1:0]     rem_q, rem_d;
    logic [DATA_W-1:0]     quo_q, quo_d;
    logic                  sgn_q, sgn_d;
    logic                  msb1_q, msb1_d;
    logic                  msb2_q, msb2_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    logic [DATA_W-1:0]     op1_mag, op2_mag;
    logic [DATA_W:0]       trial, diff;
    logic                  borrow;
    logic [DATA_W-1:0]     quo_fin, rem_fin;

    assign op1_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + DATA_W'(1)) : opdata1_i;
    assign op2_mag = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + DATA_W'(1)) : opdata2_i;

    // Partial remainder never reaches the divisor, so DATA_W+1 bits hold the trial value.
    assign trial  = {rem_q, dvd_q[DATA_W-1]};
    assign diff   = trial - {1'b0, dvs_q};
    assign borrow = diff[DATA_W];

    assign quo_fin = (sgn_q && (msb1_q ^ msb2_q)) ? (~quo_q + DATA_W'(1)) : quo_q;
    assign rem_fin = (sgn_q && msb1_q) ? (~rem_q + DATA_W'(1)) : rem_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        sgn_d    = sgn_q;
        msb1_d   = msb1_q;
        msb2_d   = msb2_q;
        result_d = result_q;
        ready_d  = ready_q;

        case (state_q)
            S_FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    cnt_d = '0;
                    if (opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d = S_ON;
                        dvd_d   = op1_mag;
                        dvs_d   = op2_mag;
                        rem_d   = '0;
                        quo_d   = '0;
                        sgn_d   = signed_div_i;
                        msb1_d  = opdata1_i[DATA_W-1];
                        msb2_d  = opdata2_i[DATA_W-1];
                    end
                end
            end

            S_BYZERO: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d  = S_END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end

            S_ON: begin
                if (annul_i) begin
                    state_d  = S_FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = S_END;
                    result_d = {rem_fin, quo_fin};
                    ready_d  = 1'b1;
                end else begin
                    rem_d = borrow ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], ~borrow};
                    dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_END: begin
                if (!start_i) begin
                    state_d  = S_FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end

            default: begin
                state_d  = S_FREE;
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FREE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            sgn_q    <= 1'b0;
            msb1_q   <= 1'b0;
            msb2_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            sgn_q    <= sgn_d;
            msb1_q   <= msb1_d;
            msb2_q   <= msb2_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: a 32-bit and an 8-bit instance sharing clock and reset.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;

    logic        s32, st32, an32, rdy32;
    logic [31:0] a32, b32;
    logic [63:0] r32;

    logic        s8, st8, an8, rdy8;
    logic [7:0]  a8, b8;
    logic [15:0] r8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_iter #(.DATA_W(32)) u_div32 (
        .clk(clk), .rst(rst), .signed_div_i(s32), .opdata1_i(a32), .opdata2_i(b32),
        .start_i(st32), .annul_i(an32), .result_o(r32), .ready_o(rdy32)
    );

    div_iter #(.DATA_W(8)) u_div8 (
        .clk(clk), .rst(rst), .signed_div_i(s8), .opdata1_i(a8), .opdata2_i(b8),
        .start_i(st8), .annul_i(an8), .result_o(r8), .ready_o(rdy8)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives a request, scrambles operands after the sampling edge, counts edges to ready.
    task automatic issue32(input logic sgn, input logic [31:0] a, input logic [31:0] b, output int lat);
        s32 = sgn; a32 = a; b32 = b; an32 = 1'b0; st32 = 1'b1;
        tick;
        a32 = ~a; b32 = 32'hDEADBEEF; s32 = ~sgn;
        lat = 0;
        while (!rdy32 && lat < 60) begin
            tick;
            lat++;
        end
    endtask

    task automatic issue8(input logic sgn, input logic [7:0] a, input logic [7:0] b, output int lat);
        s8 = sgn; a8 = a; b8 = b; an8 = 1'b0; st8 = 1'b1;
        tick;
        a8 = ~a; b8 = 8'hA5; s8 = ~sgn;
        lat = 0;
        while (!rdy8 && lat < 30) begin
            tick;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        s32 = 0; a32 = 0; b32 = 0; st32 = 0; an32 = 0;
        s8 = 0; a8 = 0; b8 = 0; st8 = 0; an8 = 0;
        repeat (3) tick;
        checks++;
        if (rdy32 !== 1'b0 || r32 !== 64'h0) begin
            failures++;
            $display("FAIL reset32: ready=%b result=%h expected ready=0 result=0", rdy32, r32);
        end
        checks++;
        if (rdy8 !== 1'b0 || r8 !== 16'h0) begin
            failures++;
            $display("FAIL reset8: ready=%b result=%h expected ready=0 result=0", rdy8, r8);
        end
        rst = 1'b1;
        tick;
    endtask

    task automatic test_unsigned;
        int lat;
        issue32(1'b0, 32'd100, 32'd7, lat);
        checks++;
        if (lat !== 33) begin
            failures++;
            $display("FAIL udiv_latency: got %0d expected 33", lat);
        end
        checks++;
        if (r32 !== 64'h00000002_0000000E) begin
            failures++;
            $display("FAIL udiv_result: got %h expected %h", r32, 64'h00000002_0000000E);
        end
        repeat (3) tick;
        checks++;
        if (rdy32 !== 1'b1 || r32 !== 64'h00000002_0000000E) begin
            failures++;
            $display("FAIL end_hold: ready=%b result=%h expected ready=1 result=%h", rdy32, r32, 64'h00000002_0000000E);
        end
        an32 = 1'b1;
        tick;
        an32 = 1'b0;
        checks++;
        if (rdy32 !== 1'b1 || r32 !== 64'h00000002_0000000E) begin
            failures++;
            $display("FAIL end_annul_ignored: ready=%b result=%h expected ready=1 result=%h", rdy32, r32, 64'h00000002_0000000E);
        end
        st32 = 1'b0;
        tick;
        checks++;
        if (rdy32 !== 1'b0 || r32 !== 64'h0) begin
            failures++;
            $display("FAIL udiv_release: ready=%b result=%h expected ready=0 result=0", rdy32, r32);
        end
    endtask

    task automatic test_signed;
        logic        sgn_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] a_t   [4] = '{32'hFFFFFFF9, 32'h00000007, 32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] b_t   [4] = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00000002};
        logic [63:0] exp_t [4] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
                                   64'hFFFFFFFF_00000003, 64'h00000001_7FFFFFFC};
        int lat;
        for (int i = 0; i < 4; i++) begin
            issue32(sgn_t[i], a_t[i], b_t[i], lat);
            checks++;
            if (lat !== 33 || r32 !== exp_t[i]) begin
                failures++;
                $display("FAIL signed_vec%0d: latency=%0d result=%h expected latency=33 result=%h", i, lat, r32, exp_t[i]);
            end
            st32 = 1'b0;
            tick;
        end
    endtask

    task automatic test_byzero;
        int lat;
        issue32(1'b0, 32'h12345678, 32'h0, lat);
        checks++;
        if (lat !== 2 || r32 !== 64'h0) begin
            failures++;
            $display("FAIL byzero_u: latency=%0d result=%h expected latency=2 result=0", lat, r32);
        end
        st32 = 1'b0;
        tick;
        issue32(1'b1, 32'h80000000, 32'h0, lat);
        checks++;
        if (lat !== 2 || r32 !== 64'h0) begin
            failures++;
            $display("FAIL byzero_s: latency=%0d result=%h expected latency=2 result=0", lat, r32);
        end
        st32 = 1'b0;
        tick;
        checks++;
        if (rdy32 !== 1'b0) begin
            failures++;
            $display("FAIL byzero_release: ready=%b expected 0", rdy32);
        end
    endtask

    task automatic test_annul;
        int lat;
        logic seen;
        s32 = 1'b0; a32 = 32'd1000; b32 = 32'd3; an32 = 1'b0; st32 = 1'b1;
        tick;
        repeat (9) tick;
        an32 = 1'b1; st32 = 1'b0;
        tick;
        an32 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rdy32 !== 1'b0) seen = 1'b1;
            tick;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL annul_no_result: ready seen=%b expected 0", seen);
        end
        issue32(1'b0, 32'd1000, 32'd3, lat);
        checks++;
        if (lat !== 33 || r32 !== 64'h00000001_0000014D) begin
            failures++;
            $display("FAIL annul_reissue: latency=%0d result=%h expected latency=33 result=%h", lat, r32, 64'h00000001_0000014D);
        end
        st32 = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        int lat;
        issue32(1'b0, 32'd100, 32'd7, lat);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (rdy32 !== 1'b0 || r32 !== 64'h0) begin
            failures++;
            $display("FAIL reset_in_end: ready=%b result=%h expected ready=0 result=0", rdy32, r32);
        end
        st32 = 1'b0;
        #1 rst = 1'b1;
        tick;
        s32 = 1'b0; a32 = 32'd1000; b32 = 32'd3; st32 = 1'b1;
        tick;
        repeat (5) tick;
        st32 = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (rdy32 !== 1'b0 || r32 !== 64'h0) begin
            failures++;
            $display("FAIL reset_in_on: ready=%b result=%h expected ready=0 result=0", rdy32, r32);
        end
        #1 rst = 1'b1;
        repeat (40) tick;
        checks++;
        if (rdy32 !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_partial: ready=%b expected 0", rdy32);
        end
        issue32(1'b0, 32'd9, 32'd3, lat);
        checks++;
        if (lat !== 33 || r32 !== 64'h00000000_00000003) begin
            failures++;
            $display("FAIL reset_reissue: latency=%0d result=%h expected latency=33 result=%h", lat, r32, 64'h3);
        end
        st32 = 1'b0;
        tick;
    endtask

    task automatic test_overflow;
        int lat;
        issue32(1'b1, 32'h80000000, 32'hFFFFFFFF, lat);
        checks++;
        if (lat !== 33 || r32 !== 64'h00000000_80000000) begin
            failures++;
            $display("FAIL overflow: latency=%0d result=%h expected latency=33 result=%h", lat, r32, 64'h80000000);
        end
        st32 = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        int lat;
        issue32(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        checks++;
        if (lat !== 33 || r32 !== 64'h00000000_00000001) begin
            failures++;
            $display("FAIL b2b_first: latency=%0d result=%h expected latency=33 result=%h", lat, r32, 64'h1);
        end
        st32 = 1'b0;
        tick;
        issue32(1'b0, 32'd5, 32'd10, lat);
        checks++;
        if (lat !== 33 || r32 !== 64'h00000005_00000000) begin
            failures++;
            $display("FAIL b2b_second: latency=%0d result=%h expected latency=33 result=%h", lat, r32, 64'h00000005_00000000);
        end
        st32 = 1'b0;
        tick;
    endtask

    task automatic test_w8;
        int lat;
        issue8(1'b0, 8'hF0, 8'h03, lat);
        checks++;
        if (lat !== 9 || r8 !== 16'h0050) begin
            failures++;
            $display("FAIL w8_unsigned: latency=%0d result=%h expected latency=9 result=0050", lat, r8);
        end
        st8 = 1'b0;
        tick;
        issue8(1'b1, 8'hF0, 8'h03, lat);
        checks++;
        if (lat !== 9 || r8 !== 16'hFFFB) begin
            failures++;
            $display("FAIL w8_signed: latency=%0d result=%h expected latency=9 result=FFFB", lat, r8);
        end
        st8 = 1'b0;
        tick;
        issue8(1'b0, 8'h42, 8'h00, lat);
        checks++;
        if (lat !== 2 || r8 !== 16'h0000) begin
            failures++;
            $display("FAIL w8_byzero: latency=%0d result=%h expected latency=2 result=0000", lat, r8);
        end
        st8 = 1'b0;
        tick;
        checks++;
        if (rdy8 !== 1'b0 || r8 !== 16'h0) begin
            failures++;
            $display("FAIL w8_release: ready=%b result=%h expected ready=0 result=0", rdy8, r8);
        end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_byzero;
        test_annul;
        test_reset_mid;
        test_overflow;
        test_back_to_back;
        test_w8;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
